fir_decim_requant: RTL and testbench

Output stage placed directly after the FIR filter. It takes the filter's 16-bit signed result stream, keeps one sample in every DECIM, and rescales it by rounding and an arithmetic right shift. It saturates the result to an OUT_W-bit signed sample. Results are buffered in a small FIFO and presented on a valid/ready interface to the consumer.

---
 rtl/fir_pkg.sv | 18 +
 rtl/sync_fifo.sv | 53 +++++
 rtl/fir_decim_requant.sv | 86 ++++++++
 tb/tb_fir_decim_requant.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants and helpers for the FIR datapath and its output stages.
package fir_pkg;
  localparam int ACC_W    = 16;
  localparam int SAMPLE_W = 8;

  typedef logic signed [ACC_W:0] wide_t;

  // Clip a widened filter value into the signed range of an out_w-bit sample.
  function automatic wide_t saturate(input wide_t v, input int out_w);
    wide_t hi;
    wide_t lo;
    hi = wide_t'((1 << (out_w - 1)) - 1);
    lo = -hi - wide_t'(1);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head word; the head always shows the oldest entry.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when the same cycle frees the head slot.
  assign do_push = push && (!full || do_pop);
  assign rd_next = rd_ptr + AW'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdata  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_next;
      count  <= count + CW'(do_push) - CW'(do_pop);
      if (do_push && (count == CW'(do_pop)))
        rdata <= wdata;
      else if (count > CW'(do_pop))
        rdata <= mem[rd_next];
    end
  end
endmodule

// File: rtl/fir_decim_requant.sv
// FIR output stage: decimate, round-and-shift, saturate, then buffer for the consumer.
module fir_decim_requant
  import fir_pkg::*;
#(
  parameter int DECIM = 4,
  parameter int SHIFT = 4,
  parameter int OUT_W = SAMPLE_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ACC_W-1:0] y_in,
  input  logic             in_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sat,
  output logic             drop,
  output logic             overrun
);
  localparam int    PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam wide_t RND  = wide_t'((1 << SHIFT) >> 1);

  logic [PH_W-1:0]     phase;
  logic                accept;
  wide_t               sum;
  wide_t               s1_r;
  wide_t               clipped;
  logic                s1_valid;
  logic                s2_valid;
  logic                s2_sat;
  logic [OUT_W-1:0]    s2_data;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic [$clog2(DEPTH):0] fifo_count;

  assign accept  = in_valid && (phase == '0);
  assign sum     = {y_in[ACC_W-1], y_in} + RND;
  assign clipped = saturate(s1_r, OUT_W);

  always_ff @(posedge clk) begin
    if (reset) begin
      phase    <= '0;
      s1_valid <= 1'b0;
      s1_r     <= '0;
      s2_valid <= 1'b0;
      s2_sat   <= 1'b0;
      s2_data  <= '0;
      overrun  <= 1'b0;
    end else begin
      if (in_valid)
        phase <= (phase == PH_W'(DECIM - 1)) ? '0 : phase + 1'b1;
      s1_valid <= accept;
      if (accept) s1_r <= sum >>> SHIFT;
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= clipped[OUT_W-1:0];
        s2_sat  <= (clipped != s1_r);
      end
      if (drop) overrun <= 1'b1;
    end
  end

  // Output handshake: a word transfers on any rising edge where out_valid and
  // out_ready are both high; out_data stays frozen while out_valid waits on out_ready.
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign sat       = s2_valid && s2_sat;
  assign drop      = s2_valid && fifo_full && !pop;

  sync_fifo #(.WIDTH(OUT_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (s2_valid),
    .pop   (pop),
    .wdata (s2_data),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  a_count_range : assert property (@(posedge clk) disable iff (reset)
    (fifo_count <= ($clog2(DEPTH)+1)'(DEPTH)) && (fifo_full == (fifo_count == ($clog2(DEPTH)+1)'(DEPTH))));
endmodule

// File: tb/tb_fir_decim_requant.sv
// Directed bench for fir_decim_requant at DECIM=4, SHIFT=4, OUT_W=8, DEPTH=4.
module tb_fir_decim_requant;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] y_in;
  logic        in_valid;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        sat;
  logic        drop;
  logic        overrun;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  fir_decim_requant #(.DECIM(4), .SHIFT(4), .OUT_W(8), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .y_in      (y_in),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sat       (sat),
    .drop      (drop),
    .overrun   (overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // One kept sample in a group of four valid cycles, FIFO empty, out_ready high.
  task automatic check_sample(input logic [15:0] y, input logic [7:0] exp, input logic exp_sat);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    y_in      = y;
    tick();
    check("smp_valid_t0", out_valid, 0);
    y_in = 16'd0;
    tick();
    check("smp_sat", sat, exp_sat);
    check("smp_valid_t1", out_valid, 0);
    tick();
    check("smp_valid_t2", out_valid, 1);
    check("smp_data", out_data, exp);
    check("smp_sat_after", sat, 0);
    tick();
    check("smp_popped", out_valid, 0);
    in_valid = 1'b0;
  endtask

  task automatic drain_queue(input string tag);
    out_ready = 1'b1;
    while (exp_q.size() > 0) begin
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_data"}, out_data, exp_q.pop_front());
      tick();
    end
    check({tag, "_empty"}, out_valid, 0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; y_in = 16'd0;
    tick();
    tick();
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_sat", sat, 0);
    check("rst_drop", drop, 0);
    check("rst_overrun", overrun, 0);
    reset = 1'b0;

    // Ramp: kept samples 0,4,8,.. appear two edges after acceptance
    out_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      y_in = 16'(16 * n);
      in_valid = 1'b1;
      tick();
      check("ramp_valid", out_valid, (n >= 2 && (n % 4) == 2) ? 1 : 0);
      if (n >= 2 && (n % 4) == 2) check("ramp_data", out_data, 16'(n - 2));
      check("ramp_sat", sat, 0);
    end
    in_valid = 1'b0;

    // Rounding and saturation
    check_sample(16'd100,    8'd6,   1'b0);
    check_sample(16'hFF9C,   8'hFA,  1'b0);
    check_sample(16'd8,      8'd1,   1'b0);
    check_sample(16'hFFF7,   8'hFF,  1'b0);
    check_sample(16'h7FFF,   8'h7F,  1'b1);
    check_sample(16'h8000,   8'h80,  1'b1);
    check_sample(16'd2040,   8'h7F,  1'b1);

    // Backpressure: FIFO keeps 0,4,8,12; later pushes drop
    out_ready = 1'b0;
    exp_q = '{8'd0, 8'd4, 8'd8, 8'd12};
    for (int n = 0; n < 40; n++) begin
      y_in = 16'(16 * n);
      in_valid = 1'b1;
      tick();
      check("bp_drop", drop, (n >= 17 && (n % 4) == 1) ? 1 : 0);
      if (n >= 2) begin
        check("bp_valid", out_valid, 1);
        check("bp_hold", out_data, 0);
      end
      if (n == 16) check("bp_overrun_pre", overrun, 0);
    end
    in_valid = 1'b0;
    check("bp_overrun", overrun, 1);
    drain_queue("bp_drain");
    check_sample(16'd80, 8'd5, 1'b0);
    check("bp_overrun_sticky", overrun, 1);

    pulse_reset();
    check("rst2_overrun", overrun, 0);

    // Full FIFO with a pop in the push cycle: no drop
    out_ready = 1'b0;
    exp_q = '{8'd4, 8'd8, 8'd12, 8'd16};
    for (int k = 0; k < 18; k++) begin
      y_in = 16'(16 * k);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("fp_head", out_data, 0);
    out_ready = 1'b1;
    #1;
    check("fp_drop", drop, 0);
    tick();
    out_ready = 1'b0;
    check("fp_overrun", overrun, 0);
    drain_queue("fp_drain");

    // Reset with three FIFO entries and one sample in stage 1, phase nonzero
    pulse_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 13; k++) begin
      y_in = 16'(16 * k);
      in_valid = 1'b1;
      tick();
    end
    check("mr_pre_valid", out_valid, 1);
    check("mr_pre_data", out_data, 0);
    reset = 1'b1;
    y_in  = 16'h7FFF;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    check("mr_valid", out_valid, 0);
    check("mr_data", out_data, 0);
    check("mr_overrun", overrun, 0);
    check("mr_sat", sat, 0);
    check("mr_drop", drop, 0);
    check_sample(16'd112, 8'd7, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
